// File: rtl/conv_loop_pkg.sv
// Shared types and constants for the conv_loop_gen loop-nest generator.
package conv_loop_pkg;

  localparam int IDX_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/conv_loop_gen_if.sv
// Control, bound and index-stream signals of conv_loop_gen; the generator uses the slave modport.
interface conv_loop_gen_if #(
  parameter int IDX_W = conv_loop_pkg::IDX_W_DEF
);

  logic             start;
  logic             abort;
  logic [IDX_W-1:0] c_max;
  logic [IDX_W-1:0] r_max;
  logic [IDX_W-1:0] j_max;
  logic [IDX_W-1:0] i_max;
  logic             idx_ready;
  logic             idx_valid;
  logic [IDX_W-1:0] c;
  logic [IDX_W-1:0] r;
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] i;
  logic             last;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, c_max, r_max, j_max, i_max, idx_ready,
    input  idx_valid, c, r, j, i, last, busy, done
  );

  modport slave (
    input  start, abort, c_max, r_max, j_max, i_max, idx_ready,
    output idx_valid, c, r, j, i, last, busy, done
  );

endinterface

// File: rtl/conv_loop_gen_loop_level_cnt.sv
// One loop level: counts 0..i_max on i_step, flags the wrap so the next level can advance.
module loop_level_cnt #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_max,
  input  logic             i_step,
  input  logic             i_clear,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_wrap
);

  logic [IDX_W-1:0] r_idx;
  logic             w_at_max;

  assign w_at_max = (r_idx == i_max);
  assign o_wrap   = i_step && w_at_max;
  assign o_idx    = r_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_step) begin
      r_idx <= w_at_max ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/conv_loop_gen.sv
// Four-level loop-nest index generator (c innermost, i outermost) with valid/ready output stream.
module conv_loop_gen
  import conv_loop_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  conv_loop_gen_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_c_max, r_r_max, r_j_max, r_i_max;
  logic [IDX_W-1:0] w_c, w_r, w_j, w_i;
  logic             w_run;
  logic             w_accept;
  logic             w_abort;
  logic             w_step_c;
  logic             w_wrap_c, w_wrap_r, w_wrap_j, w_wrap_i;
  logic             w_clear;

  assign w_run    = (r_state == RUN);
  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_abort  = w_run && bus.abort;
  // Abort wins over a coincident transfer: the indices must not advance.
  assign w_step_c = w_run && bus.idx_ready && !w_abort;
  // w_wrap_i is exactly the transfer of the final tuple.
  assign w_clear  = w_accept || w_abort || w_wrap_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: defaults first in always_comb so no path leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (bus.start) w_state_nxt = RUN;
      RUN: begin
        if (bus.abort)     w_state_nxt = IDLE;
        else if (w_wrap_i) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_max <= '0;
      r_r_max <= '0;
      r_j_max <= '0;
      r_i_max <= '0;
    end else if (w_accept) begin
      r_c_max <= bus.c_max;
      r_r_max <= bus.r_max;
      r_j_max <= bus.j_max;
      r_i_max <= bus.i_max;
    end
  end

  loop_level_cnt #(.IDX_W(IDX_W)) u_lvl_c (
    .clk(clk), .rst(rst), .i_max(r_c_max), .i_step(w_step_c),
    .i_clear(w_clear), .o_idx(w_c), .o_wrap(w_wrap_c)
  );

  loop_level_cnt #(.IDX_W(IDX_W)) u_lvl_r (
    .clk(clk), .rst(rst), .i_max(r_r_max), .i_step(w_wrap_c),
    .i_clear(w_clear), .o_idx(w_r), .o_wrap(w_wrap_r)
  );

  loop_level_cnt #(.IDX_W(IDX_W)) u_lvl_j (
    .clk(clk), .rst(rst), .i_max(r_j_max), .i_step(w_wrap_r),
    .i_clear(w_clear), .o_idx(w_j), .o_wrap(w_wrap_j)
  );

  loop_level_cnt #(.IDX_W(IDX_W)) u_lvl_i (
    .clk(clk), .rst(rst), .i_max(r_i_max), .i_step(w_wrap_j),
    .i_clear(w_clear), .o_idx(w_i), .o_wrap(w_wrap_i)
  );

  // Valid comes from the state register only, never from idx_ready.
  assign bus.idx_valid = w_run;
  assign bus.busy      = w_run;
  assign bus.done      = (r_state == DONE);
  assign bus.c         = w_c;
  assign bus.r         = w_r;
  assign bus.j         = w_j;
  assign bus.i         = w_i;
  assign bus.last      = w_run && (w_c == r_c_max) && (w_r == r_r_max)
                              && (w_j == r_j_max) && (w_i == r_i_max);

endmodule

// File: doc/conv_loop_gen.md
CONV_LOOP_GEN -- requirements
Module: conv_loop_gen

Interface
REQ-001 Parameter: IDX_W, default 4, width of every loop index and bound.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle request to begin a loop nest; honoured only in IDLE.
REQ-005 Port: abort  input  1  synchronous cancel of a running nest.
REQ-006 Port: c_max, r_max, j_max, i_max  input  IDX_W each  inclusive upper bound per level (loop runs 0..max).
REQ-007 Port: idx_valid  output  1  index tuple on c/r/j/i is valid.
REQ-008 Port: idx_ready  input  1  consumer accepts tuple; transfer = idx_valid && idx_ready.
REQ-009 Port: c, r, j, i  output  IDX_W each  current indices; c innermost, i outermost.
REQ-010 Port: last  output  1  high with idx_valid when the tuple is the final one of the nest.
REQ-011 Port: busy  output  1  high in RUN.
REQ-012 Port: done  output  1  one-cycle pulse after the final transfer.

Function
REQ-013 States: IDLE, RUN, DONE; busy = (state == RUN).
REQ-014 IDLE + start: latch all four max inputs into shadow registers, clear indices to 0, go to RUN; idx_valid rises on the next cycle (latency 1).
REQ-015 Max inputs are sampled only at accepted start; changes during RUN have no effect.
REQ-016 start outside IDLE is ignored without side effects.
REQ-017 In RUN, idx_valid = 1; on a transfer, c increments; at c == c_max, c wraps to 0 and a carry advances r; r, j and i chain the same way with their own bounds.
REQ-018 Without a transfer (idx_ready = 0), c/r/j/i/last hold stable.
REQ-019 last = idx_valid && c==c_max && r==r_max && j==j_max && i==i_max.
REQ-020 A transfer with last = 1 moves to DONE; indices return to 0 and idx_valid drops to 0 in the same edge.
REQ-021 DONE lasts exactly one cycle with done = 1, then IDLE; a start in DONE is ignored.
REQ-022 A max of 0 makes that level a single iteration; all max = 0 gives exactly one transfer, with last = 1.
REQ-023 Total transfers per nest = (c_max+1)(r_max+1)(j_max+1)(i_max+1); order is lexicographic, with i slowest.
REQ-024 abort in RUN: go to IDLE next edge, clear indices, idx_valid = 0, no done pulse; abort takes priority over a coincident transfer.
REQ-025 abort in IDLE or DONE has no effect.
REQ-026 Index arithmetic is IDX_W unsigned; no index ever exceeds its latched max.

Reset
REQ-027 rst asserted at any time forces IDLE immediately: c=r=j=i=0, idx_valid=0, last=0, busy=0, done=0, shadow bounds = 0.
REQ-028 After rst deasserts, the block waits for a new start; an interrupted nest does not resume.

Structure
REQ-029 Shared package conv_loop_pkg holds the state enum (IDLE/RUN/DONE) and the IDX_W default constant.
REQ-030 Sub-module loop_level_cnt: one index level with input (max, step, clear) and output (idx, wrap); instantiated four times and chained wrap to step.
REQ-031 All registers are in the clk domain with asynchronous rst; no combinational path from idx_ready to idx_valid.

Verification
REQ-032 Bounds c_max=1,r_max=1,j_max=2,i_max=2, idx_ready=1 -> 36 transfers in order (0,0,0,0),(1,0,0,0),(0,1,0,0)...; last only on (1,1,2,2); done one cycle later.
REQ-033 Same bounds, idx_ready toggled pseudo-randomly -> identical 36-tuple sequence, and outputs stable on every stalled cycle.
REQ-034 All max = 0, start -> exactly one transfer (0,0,0,0) with last = 1, then done pulse, then IDLE.
REQ-035 Start again while busy, and max inputs changed mid-run -> sequence unaffected, and transfer count equals the product latched at the original start.
REQ-036 abort after 5 transfers -> idx_valid = 0 next cycle, no done, busy = 0; a following start runs a full nest from 0.
REQ-037 rst asserted mid-run (asynchronous, between edges) -> outputs are immediately at reset values; after release and a new start, the full sequence runs.
